// File: rtl/tcdm_wrr_arbiter.sv
// Weighted round-robin arbiter sharing one TCDM slave port among NumReq masters.
// The owner may keep the port for weight+1 consecutive handshakes before ownership rotates.
module tcdm_wrr_arbiter #(
  parameter int unsigned NumReq      = 8,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned WeightWidth = 4,
  localparam int unsigned IdxW       = $clog2(NumReq)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cfg_we_i,
  input  logic [IdxW-1:0]               cfg_idx_i,
  input  logic [WeightWidth-1:0]        cfg_weight_i,
  input  logic [NumReq-1:0]             req_i,
  output logic [NumReq-1:0]             gnt_o,
  input  logic [NumReq*DataWidth-1:0]   data_i,
  input  logic                          gnt_i,
  output logic                          req_o,
  output logic [DataWidth-1:0]          data_o,
  output logic [IdxW-1:0]               idx_o
);

  logic [IdxW-1:0]        r_owner;
  logic [WeightWidth-1:0] r_credit;
  logic [WeightWidth-1:0] r_weight [NumReq];

  logic [IdxW-1:0]        w_sel;
  logic [IdxW-1:0]        w_next;
  logic                   w_found;
  logic                   w_any;
  logic                   w_hs;
  logic [WeightWidth-1:0] w_eff;

  // Modular increment that also wraps correctly for non-power-of-two NumReq.
  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                               input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NumReq) s = s - NumReq;
    return IdxW'(s);
  endfunction

  // Owner keeps priority while requesting; otherwise search cyclically after it.
  always_comb begin
    w_sel   = r_owner;
    w_found = req_i[r_owner];
    for (int unsigned k = 1; k < NumReq; k++) begin
      if (!w_found && req_i[wrap_add(r_owner, k)]) begin
        w_sel   = wrap_add(r_owner, k);
        w_found = 1'b1;
      end
    end
  end

  assign w_any  = |req_i;
  assign w_hs   = w_any & gnt_i;
  assign w_next = wrap_add(w_sel, 1);
  assign w_eff  = (w_sel == r_owner) ? r_credit : r_weight[w_sel];

  always_comb begin
    req_o  = w_any;
    data_o = '0;
    idx_o  = '0;
    gnt_o  = '0;
    if (w_any) begin
      idx_o = w_sel;
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (w_sel == IdxW'(i)) begin
          data_o   = data_i[i*DataWidth +: DataWidth];
          gnt_o[i] = gnt_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner  <= '0;
      r_credit <= '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
        r_weight[i] <= '0;
      end
    end else begin
      if (w_hs) begin
        if (w_eff == '0) begin
          // Turn exhausted: hand over, preloading the pre-write weight of the successor.
          r_owner  <= w_next;
          r_credit <= r_weight[w_next];
        end else begin
          r_owner  <= w_sel;
          r_credit <= w_eff - WeightWidth'(1);
        end
      end
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (cfg_we_i && (cfg_idx_i == IdxW'(i))) begin
          r_weight[i] <= cfg_weight_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_tcdm_wrr_arbiter.sv
// Bench for tcdm_wrr_arbiter: directed scenarios plus randomized traffic against a
// turn/credit reference model kept in plain integers.
module tb_tcdm_wrr_arbiter;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int WW = 4;
  localparam int IW = 3;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              cfg_we_i;
  logic [IW-1:0]     cfg_idx_i;
  logic [WW-1:0]     cfg_weight_i;
  logic [N-1:0]      req_i;
  logic [N-1:0]      gnt_o;
  logic [N*DW-1:0]   data_i;
  logic              gnt_i;
  logic              req_o;
  logic [DW-1:0]     data_o;
  logic [IW-1:0]     idx_o;

  tcdm_wrr_arbiter #(
    .NumReq      (N),
    .DataWidth   (DW),
    .WeightWidth (WW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cfg_we_i     (cfg_we_i),
    .cfg_idx_i    (cfg_idx_i),
    .cfg_weight_i (cfg_weight_i),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .data_i       (data_i),
    .gnt_i        (gnt_i),
    .req_o        (req_o),
    .data_o       (data_o),
    .idx_o        (idx_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: whose turn it is, how many extra grants remain, programmed weights.
  int          m_owner;
  int          m_credit;
  int          m_w [N];
  logic [DW-1:0] d [N];
  int          checks;
  int          failures;

  function automatic void m_reset();
    m_owner  = 0;
    m_credit = 0;
    for (int i = 0; i < N; i++) m_w[i] = 0;
  endfunction

  function automatic int m_sel(input logic [N-1:0] r);
    if (r == '0) return 0;
    if (r[m_owner]) return m_owner;
    for (int k = 1; k < N; k++) begin
      if (r[(m_owner + k) % N]) return (m_owner + k) % N;
    end
    return 0;
  endfunction

  task automatic check_out(input string tag, input int want);
    int            s;
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    logic          er;
    logic [IW-1:0] ei;
    s  = m_sel(req_i);
    er = (req_i != '0);
    eg = '0;
    if (er && gnt_i) eg[s] = 1'b1;
    ed = er ? d[s] : '0;
    ei = er ? IW'(s) : '0;
    checks++;
    assert (req_o === er) else begin
      failures++;
      $error("FAIL %s req_o got %b exp %b", tag, req_o, er);
    end
    checks++;
    assert (idx_o === ei) else begin
      failures++;
      $error("FAIL %s idx_o got %0d exp %0d", tag, idx_o, ei);
    end
    checks++;
    assert (gnt_o === eg) else begin
      failures++;
      $error("FAIL %s gnt_o got %h exp %h", tag, gnt_o, eg);
    end
    checks++;
    assert (data_o === ed) else begin
      failures++;
      $error("FAIL %s data_o got %h exp %h", tag, data_o, ed);
    end
    if (want >= 0) begin
      checks++;
      assert (idx_o === IW'(want)) else begin
        failures++;
        $error("FAIL %s directed idx_o got %0d exp %0d", tag, idx_o, want);
      end
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic [N-1:0] r, input logic g, input logic we, input int ci,
                      input int cw, input string tag, input int want);
    int s;
    int eff;
    req_i        = r;
    gnt_i        = g;
    cfg_we_i     = we;
    cfg_idx_i    = IW'(ci);
    cfg_weight_i = WW'(cw);
    for (int i = 0; i < N; i++) begin
      d[i] = $urandom;
      data_i[i*DW +: DW] = d[i];
    end
    #1;
    check_out(tag, want);
    @(posedge clk_i);
    if (r != '0 && g) begin
      s   = m_sel(r);
      eff = (s == m_owner) ? m_credit : m_w[s];
      if (eff == 0) begin
        m_owner  = (s + 1) % N;
        m_credit = m_w[m_owner];
      end else begin
        m_owner  = s;
        m_credit = eff - 1;
      end
    end
    if (we && ci < N) m_w[ci] = cw;
    @(negedge clk_i);
  endtask

  // Reset pulse placed between clock edges; idle outputs checked while it is asserted.
  task automatic pulse_reset(input string tag);
    #2;
    rst_ni   = 1'b0;
    req_i    = '0;
    gnt_i    = 1'b0;
    cfg_we_i = 1'b0;
    #1;
    m_reset();
    check_out(tag, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    logic [N-1:0] r;
    logic         g;
    logic         we;
    int           idx_plain [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    int           idx_wt [10]   = '{2, 2, 2, 2, 3, 2, 2, 2, 2, 3};
    int           idx_col [6]   = '{7, 0, 7, 0, 0, 7};
    checks       = 0;
    failures     = 0;
    rst_ni       = 1'b0;
    cfg_we_i     = 1'b0;
    cfg_idx_i    = '0;
    cfg_weight_i = '0;
    req_i        = '0;
    gnt_i        = 1'b0;
    data_i       = '0;
    for (int i = 0; i < N; i++) d[i] = '0;
    m_reset();
    #3;
    check_out("reset_idle", 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Plain round-robin with all weights zero.
    for (int i = 0; i < 9; i++) step(8'hFF, 1'b1, 1'b0, 0, 0, "plain_rr", idx_plain[i]);

    // Weighted share: requester 2 gets weight+1 = 4 grants per turn.
    step(8'h00, 1'b0, 1'b1, 2, 3, "cfg_w2", -1);
    for (int i = 0; i < 10; i++) step(8'h0C, 1'b1, 1'b0, 0, 0, "weighted", idx_wt[i]);

    // Backpressure holds state.
    pulse_reset("rst_bp");
    for (int i = 0; i < 5; i++) step(8'h03, 1'b0, 1'b0, 0, 0, "backpressure", 0);
    step(8'h03, 1'b1, 1'b0, 0, 0, "bp_release0", 0);
    step(8'h03, 1'b1, 1'b0, 0, 0, "bp_release1", 1);

    // Owner drops its request mid-turn.
    pulse_reset("rst_drop");
    step(8'h00, 1'b0, 1'b1, 1, 2, "cfg_w1", -1);
    step(8'h02, 1'b1, 1'b0, 0, 0, "drop_setup", 1);
    step(8'h05, 1'b1, 1'b0, 0, 0, "drop_sel", 2);
    step(8'h05, 1'b1, 1'b0, 0, 0, "drop_after", 0);

    // Config write in the same cycle ownership passes to requester 0.
    pulse_reset("rst_col");
    step(8'h80, 1'b1, 1'b1, 0, 1, "collision", idx_col[0]);
    for (int i = 1; i < 6; i++) step(8'h81, 1'b1, 1'b0, 0, 0, "collision", idx_col[i]);

    // Reset in the middle of a burst.
    pulse_reset("rst_mid_pre");
    step(8'h00, 1'b0, 1'b1, 2, 3, "cfg_w2b", -1);
    step(8'h04, 1'b1, 1'b0, 0, 0, "burst_setup", 2);
    pulse_reset("rst_mid");
    step(8'h06, 1'b1, 1'b0, 0, 0, "post_rst0", 1);
    step(8'h06, 1'b1, 1'b0, 0, 0, "post_rst1", 2);

    // Randomized traffic with occasional weight writes.
    for (int n = 0; n < 400; n++) begin
      r  = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & N'($urandom);
      g  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 7) == 0);
      step(r, g, we, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 5)), "random", -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
